// File: rtl/pkt_desc_gen.sv
// -----------------------------------------------------------------------------
// pkt_desc_gen -- packet descriptor generator
//
// Emits a stream of packet descriptors {flow ID, length} to a downstream
// measure stage. A start pulse latches the cfg_* inputs and begins emission.
// One descriptor is strobed on valid every (cfg_gap + 1) cycles. Emission
// stops after cfg_pkt_count packets (0 = unlimited), on a stop pulse, or on
// reset. Flow IDs rotate through cfg_id_base .. cfg_id_base + cfg_id_num - 1.
// Lengths below 64 bytes are raised to 64.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   start          1-cycle pulse: latch cfg_* and start (ignored while busy)
//   stop           1-cycle pulse: abort; takes priority over start
//   cfg_gap        idle cycles between consecutive valid pulses
//   cfg_len        packet length in bytes
//   cfg_id_base    first flow ID
//   cfg_id_num     number of flow IDs to rotate through (0 behaves as 1)
//   cfg_pkt_count  packets to send, 0 = unlimited
//   valid          one-cycle descriptor strobe
//   lenth_Data     packet length (holds last value while valid = 0)
//   ID_Data        flow ID (holds last value while valid = 0)
//   pd_data        {ID_Data, lenth_Data}
//   busy           generator is in SEND or GAP
//   done           programmed packet count reached
//   sent_cnt       packets emitted since the last start (saturating)
//   ts_data        cycle-counter value captured at each valid
//                  (only when PKT_DESC_GEN_TIMESTAMP_EN is defined)
//
// Build option
//   PKT_DESC_GEN_TIMESTAMP_EN  adds a free-running cycle counter and ts_data.
// -----------------------------------------------------------------------------
module pkt_desc_gen #(
  parameter int C_LENTH_WIDTH   = 16,
  parameter int C_ID_WIDTH      = 16,
  parameter int C_COUNTER_WIDTH = 20,
  parameter int C_PD_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic [C_COUNTER_WIDTH-1:0] cfg_gap,
  input  logic [C_LENTH_WIDTH-1:0]   cfg_len,
  input  logic [C_ID_WIDTH-1:0]      cfg_id_base,
  input  logic [C_ID_WIDTH-1:0]      cfg_id_num,
  input  logic [C_COUNTER_WIDTH-1:0] cfg_pkt_count,
  output logic                       valid,
  output logic [C_LENTH_WIDTH-1:0]   lenth_Data,
  output logic [C_ID_WIDTH-1:0]      ID_Data,
  output logic [C_PD_WIDTH-1:0]      pd_data,
  output logic                       busy,
  output logic                       done,
  output logic [C_COUNTER_WIDTH-1:0] sent_cnt
`ifdef PKT_DESC_GEN_TIMESTAMP_EN
  ,
  output logic [C_COUNTER_WIDTH-1:0] ts_data
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [C_LENTH_WIDTH-1:0]   MIN_LEN = C_LENTH_WIDTH'(64);
  localparam logic [C_COUNTER_WIDTH-1:0] CNT_ONE = C_COUNTER_WIDTH'(1);
  localparam logic [C_COUNTER_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [C_ID_WIDTH-1:0]      ID_ONE  = C_ID_WIDTH'(1);

  state_t state_q, state_d;

  // Configuration captured at start
  logic [C_COUNTER_WIDTH-1:0] gap_q;
  logic [C_COUNTER_WIDTH-1:0] count_q;
  logic [C_LENTH_WIDTH-1:0]   len_q;
  logic [C_ID_WIDTH-1:0]      base_q;
  logic [C_ID_WIDTH-1:0]      num_q;

  // Running state
  logic [C_COUNTER_WIDTH-1:0] gap_cnt_q;   // GAP cycles spent so far
  logic [C_ID_WIDTH-1:0]      idx_q;       // offset of next ID from base

  logic                       launch;      // start accepted this cycle
  logic                       emit;        // a descriptor is strobed next cycle
  logic [C_LENTH_WIDTH-1:0]   len_cur;
  logic [C_ID_WIDTH-1:0]      base_cur;
  logic [C_ID_WIDTH-1:0]      num_cur;
  logic [C_ID_WIDTH-1:0]      idx_cur;
  logic [C_ID_WIDTH-1:0]      id_cur;
  logic                       id_last;
  logic [C_COUNTER_WIDTH-1:0] sent_base;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    launch  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start && !stop) begin
          state_d = SEND;
          launch  = 1'b1;
        end
      end
      SEND: begin
        // sent_cnt already includes the packet strobed in this cycle
        if (stop)
          state_d = IDLE;
        else if ((count_q != '0) && (sent_cnt == count_q))
          state_d = DONE;
        else if (gap_q == '0)
          state_d = SEND;
        else
          state_d = GAP;
      end
      GAP: begin
        if (stop)
          state_d = IDLE;
        else if (gap_cnt_q == gap_q)
          state_d = SEND;
        else
          state_d = GAP;
      end
      default: state_d = IDLE;
    endcase

    emit = (state_d == SEND);
  end

  // ---------------------------------------------------------------------------
  // Descriptor datapath. On the launch cycle the config registers are being
  // loaded on the same edge, so the first descriptor is built from cfg_*.
  // ---------------------------------------------------------------------------
  always_comb begin
    len_cur   = launch ? ((cfg_len < MIN_LEN) ? MIN_LEN : cfg_len) : len_q;
    base_cur  = launch ? cfg_id_base : base_q;
    num_cur   = launch ? cfg_id_num  : num_q;
    idx_cur   = launch ? '0          : idx_q;
    id_cur    = base_cur + idx_cur;  // wraps modulo 2^C_ID_WIDTH
    // num of 0 or 1 keeps the ID fixed at base
    id_last   = (num_cur <= ID_ONE) || (idx_cur == (num_cur - ID_ONE));
    sent_base = launch ? '0 : sent_cnt;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      valid      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      lenth_Data <= '0;
      ID_Data    <= '0;
      pd_data    <= '0;
      sent_cnt   <= '0;
      gap_q      <= '0;
      count_q    <= '0;
      len_q      <= '0;
      base_q     <= '0;
      num_q      <= '0;
      gap_cnt_q  <= '0;
      idx_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values regardless of statement order.
      state_q <= state_d;
      valid   <= emit;
      busy    <= (state_d == SEND) || (state_d == GAP);
      done    <= (state_d == DONE);

      if (launch) begin
        gap_q   <= cfg_gap;
        count_q <= cfg_pkt_count;
        len_q   <= len_cur;
        base_q  <= cfg_id_base;
        num_q   <= cfg_id_num;
      end

      if (state_d == GAP)
        gap_cnt_q <= (state_q == GAP) ? (gap_cnt_q + CNT_ONE) : CNT_ONE;

      if (emit) begin
        lenth_Data <= len_cur;
        ID_Data    <= id_cur;
        pd_data    <= C_PD_WIDTH'({id_cur, len_cur});
        sent_cnt   <= (sent_base == CNT_MAX) ? sent_base : (sent_base + CNT_ONE);
        idx_q      <= id_last ? '0 : (idx_cur + ID_ONE);
      end
    end
  end

`ifdef PKT_DESC_GEN_TIMESTAMP_EN
  // Free-running cycle counter; ts_data captures it alongside each valid.
  logic [C_COUNTER_WIDTH-1:0] ts_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt_q <= '0;
      ts_data  <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + CNT_ONE;
      if (emit)
        ts_data <= ts_cnt_q;
    end
  end
`endif

endmodule

// File: tb/tb_pkt_desc_gen.sv
// -----------------------------------------------------------------------------
// tb_pkt_desc_gen -- self-checking bench for pkt_desc_gen
//
// The reference model describes a burst arithmetically: packet k of a burst
// appears k*(gap+1) cycles after the start edge, carries ID
// base + (k mod max(num,1)) and length max(len,64). Directed bursts cover the
// documented scenarios; randomized bursts vary every configuration field.
// -----------------------------------------------------------------------------
module tb_pkt_desc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [19:0] cfg_gap;
  logic [15:0] cfg_len;
  logic [15:0] cfg_id_base;
  logic [15:0] cfg_id_num;
  logic [19:0] cfg_pkt_count;
  logic        valid;
  logic [15:0] lenth_Data;
  logic [15:0] ID_Data;
  logic [31:0] pd_data;
  logic        busy;
  logic        done;
  logic [19:0] sent_cnt;
`ifdef PKT_DESC_GEN_TIMESTAMP_EN
  logic [19:0] ts_data;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  pkt_desc_gen dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .cfg_gap       (cfg_gap),
    .cfg_len       (cfg_len),
    .cfg_id_base   (cfg_id_base),
    .cfg_id_num    (cfg_id_num),
    .cfg_pkt_count (cfg_pkt_count),
    .valid         (valid),
    .lenth_Data    (lenth_Data),
    .ID_Data       (ID_Data),
    .pd_data       (pd_data),
    .busy          (busy),
    .done          (done),
    .sent_cnt      (sent_cnt)
`ifdef PKT_DESC_GEN_TIMESTAMP_EN
    ,
    .ts_data       (ts_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(valid),      64'(0));
    check({tag, "_busy"},  64'(busy),       64'(0));
    check({tag, "_done"},  64'(done),       64'(0));
    check({tag, "_len"},   64'(lenth_Data), 64'(0));
    check({tag, "_id"},    64'(ID_Data),    64'(0));
    check({tag, "_pd"},    64'(pd_data),    64'(0));
    check({tag, "_cnt"},   64'(sent_cnt),   64'(0));
  endtask

  // One burst from start to its end (done, or stop on packet stop_on).
  // glitch: change cfg_* and re-pulse start while busy; neither may matter.
  task automatic run_burst(input int gap, input int len, input int base,
                           input int num, input int count, input int stop_on,
                           input bit glitch);
    int          n, period, c_last, num_eff, exp_len, k;
    logic [15:0] exp_id;
`ifdef PKT_DESC_GEN_TIMESTAMP_EN
    logic [19:0] prev_ts = '0;
`endif
    n       = (stop_on != 0) ? stop_on : count;
    period  = gap + 1;
    c_last  = (n - 1) * period;
    num_eff = (num == 0) ? 1 : num;
    exp_len = (len < 64) ? 64 : len;

    @(negedge clk);
    cfg_gap       = 20'(gap);
    cfg_len       = 16'(len);
    cfg_id_base   = 16'(base);
    cfg_id_num    = 16'(num);
    cfg_pkt_count = 20'(count);
    start         = 1'b1;

    for (int c = 0; c <= c_last + 1; c++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      if (glitch && c == 0) begin
        cfg_gap       = 20'($urandom_range(0, 7));
        cfg_len       = 16'($urandom);
        cfg_id_base   = 16'($urandom);
        cfg_id_num    = 16'($urandom_range(0, 9));
        cfg_pkt_count = 20'($urandom_range(0, 9));
      end
      if (glitch && c == 1 && c_last >= 2)
        start = 1'b1;

      if (c <= c_last) begin
        k      = c / period;
        exp_id = 16'(base + (k % num_eff));
        check("valid", 64'(valid),      64'((c % period) == 0));
        check("busy",  64'(busy),       64'(1));
        check("done",  64'(done),       64'(0));
        check("id",    64'(ID_Data),    64'(exp_id));
        check("len",   64'(lenth_Data), 64'(exp_len));
        check("pd",    64'(pd_data),    64'({exp_id, 16'(exp_len)}));
        check("cnt",   64'(sent_cnt),   64'(k + 1));
`ifdef PKT_DESC_GEN_TIMESTAMP_EN
        if ((c % period) == 0) begin
          if (k > 0)
            check("ts_step", 64'(20'(ts_data - prev_ts)), 64'(period));
          prev_ts = ts_data;
        end
`endif
        if (c == c_last && stop_on != 0)
          stop = 1'b1;
      end else begin
        exp_id = 16'(base + ((n - 1) % num_eff));
        check("end_valid", 64'(valid),      64'(0));
        check("end_busy",  64'(busy),       64'(0));
        check("end_done",  64'(done),       64'(stop_on == 0));
        check("end_cnt",   64'(sent_cnt),   64'(n));
        check("end_id",    64'(ID_Data),    64'(exp_id));
        check("end_len",   64'(lenth_Data), 64'(exp_len));
      end
    end
  endtask

  initial begin
    int g, l, b, nm, cnt, so;

    reset         = 1'b1;
    start         = 1'b0;
    stop          = 1'b0;
    cfg_gap       = '0;
    cfg_len       = '0;
    cfg_id_base   = '0;
    cfg_id_num    = '0;
    cfg_pkt_count = '0;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 5 packets, one per 10 cycles, ID 4, length 64, pd 0x00040040, then done
    run_burst(9, 64, 4, 1, 5, 0, 1'b0);
    check("req034_pd", 64'(pd_data), 64'h0000_0000_0004_0040);

    // Back-to-back with ID wrap past 0xFFFF
    run_burst(0, 200, 'hFFFE, 3, 4, 0, 1'b0);

    // Length clamp and pass-through
    run_burst(1, 40, 12, 2, 3, 0, 1'b0);
    run_burst(0, 1500, 77, 0, 2, 0, 1'b0);

    // Unlimited count, stop on the 3rd valid
    run_burst(2, 100, 10, 2, 0, 3, 1'b0);

    // Start and config changes while busy are ignored
    run_burst(3, 300, 20, 3, 4, 0, 1'b1);

    // Randomized bursts
    for (int i = 0; i < 10; i++) begin
      g   = int'($urandom_range(0, 4));
      l   = int'($urandom_range(0, 2000));
      b   = int'($urandom_range(0, 65535));
      nm  = int'($urandom_range(0, 5));
      cnt = int'($urandom_range(0, 6));
      so  = 0;
      if (cnt == 0 || $urandom_range(0, 2) == 0)
        so = int'($urandom_range(1, (cnt == 0) ? 5 : cnt));
      run_burst(g, l, b, nm, cnt, so, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a GAP: outputs drop without waiting for a clock
    @(negedge clk);
    cfg_gap       = 20'd5;
    cfg_len       = 16'd100;
    cfg_id_base   = 16'd7;
    cfg_id_num    = 16'd2;
    cfg_pkt_count = 20'd0;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_pre_valid", 64'(valid), 64'(1));
    @(negedge clk);
    check("rst_pre_busy", 64'(busy), 64'(1));
    #2 reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    reset = 1'b0;

    // start and stop together: stop wins, generator stays idle
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("ss_valid", 64'(valid),    64'(0));
      check("ss_busy",  64'(busy),     64'(0));
      check("ss_done",  64'(done),     64'(0));
      check("ss_cnt",   64'(sent_cnt), 64'(0));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pkt_desc_gen.md
PKT_DESC_GEN -- requirements
Module: pkt_desc_gen

Interface
REQ-001 SHALL have parameters: C_LENTH_WIDTH, 16, packet length width; C_ID_WIDTH, 16, flow-ID width; C_COUNTER_WIDTH, 20, gap/count/timestamp width; C_PD_WIDTH, 32, packet-descriptor width.
REQ-002 SHALL use one clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-003 clk  input  1  rising-edge clock, 100 MHz nominal.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse; latches cfg_* and begins generation.
REQ-006 stop  input  1  single-cycle pulse; aborts generation.
REQ-007 cfg_gap  input  C_COUNTER_WIDTH  idle cycles between consecutive valid pulses.
REQ-008 cfg_len  input  C_LENTH_WIDTH  packet length in bytes.
REQ-009 cfg_id_base  input  C_ID_WIDTH  first flow ID.
REQ-010 cfg_id_num  input  C_ID_WIDTH  number of flow IDs to rotate through.
REQ-011 cfg_pkt_count  input  C_COUNTER_WIDTH  packets to send; 0 = unlimited.
REQ-012 valid  output  1  one-cycle descriptor strobe to the downstream measure stage.
REQ-013 lenth_Data  output  C_LENTH_WIDTH  packet length, qualified by valid.
REQ-014 ID_Data  output  C_ID_WIDTH  flow ID, qualified by valid.
REQ-015 pd_data  output  C_PD_WIDTH  {ID_Data, lenth_Data}, qualified by valid.
REQ-016 busy  output  1  high in SEND or GAP.
REQ-017 done  output  1  high in DONE.
REQ-018 sent_cnt  output  C_COUNTER_WIDTH  packets emitted since last start.

Function
REQ-019 SHALL implement FSM states IDLE, SEND, GAP, DONE; all outputs registered.
REQ-020 IDLE/DONE + start (no stop): latch config, clear sent_cnt, ID := cfg_id_base; next cycle SEND.
REQ-021 SEND: valid=1 for exactly one cycle; sent_cnt increments same edge, saturating at all-ones.
REQ-022 After SEND: if cfg_pkt_count!=0 and new sent_cnt==cfg_pkt_count -> DONE; else cfg_gap==0 -> SEND (back-to-back); else GAP.
REQ-023 GAP: hold exactly cfg_gap cycles with valid=0, then SEND; period = cfg_gap+1 cycles (gap 9 -> one packet per 10 clk).
REQ-024 Latched length below 64 SHALL be clamped to 64.
REQ-025 ID SHALL step base, base+1, ..., base+num-1, then wrap to base; num 0 treated as 1; addition modulo 2^C_ID_WIDTH.
REQ-026 lenth_Data/ID_Data/pd_data SHALL hold last emitted values when valid=0.
REQ-027 stop in SEND/GAP -> IDLE next edge; a valid in the same cycle as stop is still emitted and counted.
REQ-028 start and stop same cycle: stop wins, start ignored; start while busy ignored; cfg_* changes while busy ignored.
REQ-029 DONE holds done=1 and sent_cnt until next start or reset.

Reset
REQ-030 reset SHALL force IDLE immediately; valid, busy, done=0; lenth_Data, ID_Data, pd_data, sent_cnt=0.
REQ-031 reset asserted mid-burst SHALL drop valid asynchronously without completing the packet; generation resumes only on a new start.

Configuration
REQ-032 Macro PKT_DESC_GEN_TIMESTAMP_EN defined: free-running C_COUNTER_WIDTH cycle counter (cleared by reset, wraps) and output ts_data (C_COUNTER_WIDTH) holding counter value at each valid.
REQ-033 Macro undefined: no timestamp counter, no ts_data port; all other behaviour identical.

Verification
REQ-034 start, gap=9, len=64, base=4, num=1, count=5 -> 5 valid pulses 10 cycles apart, ID=4, len=64, pd=0x00040040, then done=1, sent_cnt=5.
REQ-035 gap=0, base=0xFFFE, num=3, count=4 -> valid 4 consecutive cycles, IDs FFFE, FFFF, 0000, FFFE.
REQ-036 len=40 -> lenth_Data=64; len=1500 -> lenth_Data=1500.
REQ-037 count=0, gap=2; stop on 3rd valid -> 3 valids counted, busy=0 next cycle, done=0.
REQ-038 reset pulse mid-GAP -> all outputs 0 immediately; start+stop same cycle afterward -> remains IDLE.
REQ-039 With PKT_DESC_GEN_TIMESTAMP_EN, gap=9 -> consecutive ts_data values differ by exactly 10.
